// File: rtl/wb_data_ram_slave.sv
// ----------------------------------------------------------------------------
// wb_data_ram_slave
// Wishbone B3 classic-cycle slave: word-addressed 32-bit data RAM with
// programmable wait states and error termination for misaligned or
// out-of-range byte addresses.
//
// Parameters
//   ADDR_W       word-address width; depth = 2**ADDR_W words
//   WAIT_STATES  extra cycles between request sample and ack/err (0..15)
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//
// Ports
//   clk       system clock, all state on rising edge
//   rst       asynchronous reset, active-low
//   wb_cyc_i  bus cycle in progress
//   wb_stb_i  strobe / request valid
//   wb_we_i   1 = write, 0 = read
//   wb_adr_i  byte address
//   wb_sel_i  byte-lane enables, sel[i] -> dat[8i+7:8i]
//   wb_dat_i  write data
//   wb_dat_o  read data, non-zero only in the ack cycle of a read
//   wb_ack_o  normal termination, one-cycle pulse
//   wb_err_o  error termination, one-cycle pulse
// ----------------------------------------------------------------------------
module wb_data_ram_slave #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned Depth   = 2 ** ADDR_W;
    localparam logic [3:0]  CntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] adr_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic        ack_q, err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [Depth];

    logic              req;
    logic              cur_we;
    logic [31:0]       cur_adr;
    logic [3:0]        cur_sel;
    logic [31:0]       cur_dat;
    logic [31:0]       offset;
    logic [ADDR_W-1:0] idx;
    logic              addr_bad;
    logic              enter_resp;
    logic              mem_we;

    assign req = wb_cyc_i & wb_stb_i;

    // With zero wait states the access completes on the sampling edge itself,
    // so the bus inputs are used directly; otherwise the latched copy is used.
    always_comb begin
        cur_we  = we_q;
        cur_adr = adr_q;
        cur_sel = sel_q;
        cur_dat = dat_q;
        if (state_q == StIdle) begin
            cur_we  = wb_we_i;
            cur_adr = wb_adr_i;
            cur_sel = wb_sel_i;
            cur_dat = wb_dat_i;
        end
    end

    // Offset wraps below BASE_ADDR; the explicit compare catches that case.
    assign offset   = cur_adr - BASE_ADDR;
    assign idx      = offset[ADDR_W+1:2];
    assign addr_bad = (cur_adr[1:0] != 2'b00) || (cur_adr < BASE_ADDR) ||
                      ((offset >> (ADDR_W + 2)) != 32'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        cnt_d   = CntInit;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign enter_resp = (state_d == StResp);
    // Gate with rst so an edge seen while reset is held never commits a write.
    assign mem_we     = enter_resp & cur_we & ~addr_bad & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == StIdle) && req) begin
                we_q  <= wb_we_i;
                adr_q <= wb_adr_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
            end
            ack_q   <= enter_resp & ~addr_bad;
            err_q   <= enter_resp & addr_bad;
            rdata_q <= (enter_resp && !addr_bad && !cur_we) ? mem[idx] : 32'd0;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_sel[i]) begin
                    mem[idx][8*i +: 8] <= cur_dat[8*i +: 8];
                end
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = rdata_q;

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// Scoreboard bench: two slaves (1 and 0 wait states). Stimulus pushes the
// expected response (err flag, data, cycle of arrival) per access; a monitor
// pops and compares whenever ack or err is seen.
module tb_wb_data_ram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_cyc, a_stb, a_we, a_ack, a_err;
    logic [31:0] a_adr, a_dat, a_rdat;
    logic [3:0]  a_sel;
    logic        b_cyc, b_stb, b_we, b_ack, b_err;
    logic [31:0] b_adr, b_dat, b_rdat;
    logic [3:0]  b_sel;

    wb_data_ram_slave #(.ADDR_W(10), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .rst(rst),
        .wb_cyc_i(a_cyc), .wb_stb_i(a_stb), .wb_we_i(a_we), .wb_adr_i(a_adr),
        .wb_sel_i(a_sel), .wb_dat_i(a_dat), .wb_dat_o(a_rdat),
        .wb_ack_o(a_ack), .wb_err_o(a_err)
    );

    wb_data_ram_slave #(.ADDR_W(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .rst(rst),
        .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_we_i(b_we), .wb_adr_i(b_adr),
        .wb_sel_i(b_sel), .wb_dat_i(b_dat), .wb_dat_o(b_rdat),
        .wb_ack_o(b_ack), .wb_err_o(b_err)
    );

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    task automatic mon_one(input string nm, input bit is_b, input logic ack, input logic err,
                           input logic [31:0] dat);
        exp_t e;
        bit   empty;
        if (ack && err) check({nm, " ack_and_err"}, 32'd1, 32'd0);
        if (ack || err) begin
            empty = is_b ? (qb.size() == 0) : (qa.size() == 0);
            if (empty) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s unexpected_response: got ack=%0b err=%0b, expected none (cycle %0d)",
                         nm, ack, err, cyc_cnt);
            end else begin
                if (is_b) e = qb.pop_front();
                else      e = qa.pop_front();
                check({nm, " err"}, {31'd0, err}, {31'd0, e.err});
                check({nm, " ack"}, {31'd0, ack}, {31'd0, ~e.err});
                check({nm, " dat"}, dat, e.dat);
                check({nm, " latency_cycle"}, cyc_cnt, e.cyc);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_one("A", 1'b0, a_ack, a_err, a_rdat);
            mon_one("B", 1'b1, b_ack, b_err, b_rdat);
        end
    end

    // Called just after a negedge with the slave idle; returns one cycle after
    // the termination so the slave is idle again.
    task automatic xfer(input bit is_b, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        input logic exp_err, input logic [31:0] exp_dat);
        exp_t e;
        int   t;
        bit   done;
        e.err = exp_err;
        e.dat = exp_dat;
        e.cyc = cyc_cnt + 1 + (is_b ? 0 : 1);
        if (is_b) begin
            b_cyc = 1; b_stb = 1; b_we = we; b_adr = adr; b_sel = sel; b_dat = dat;
            qb.push_back(e);
        end else begin
            a_cyc = 1; a_stb = 1; a_we = we; a_adr = adr; a_sel = sel; a_dat = dat;
            qa.push_back(e);
        end
        t = 0;
        done = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
            done = is_b ? (b_ack || b_err) : (a_ack || a_err);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout adr=%h: got no termination, expected ack/err", adr);
        end
        if (is_b) begin b_cyc = 0; b_stb = 0; end
        else      begin a_cyc = 0; a_stb = 0; end
        @(negedge clk);
    endtask

    logic [31:0] rd_adr [3];
    logic [31:0] rd_dat [3];

    initial begin : stim
        exp_t e;
        int   t;
        int   c;
        rst = 0;
        a_cyc = 0; a_stb = 0; a_we = 0; a_adr = 0; a_sel = 0; a_dat = 0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_adr = 0; b_sel = 0; b_dat = 0;
        rd_adr[0] = 32'h0; rd_adr[1] = 32'h4; rd_adr[2] = 32'h8;
        rd_dat[0] = 32'h1111_0000; rd_dat[1] = 32'h2222_0004; rd_dat[2] = 32'h3333_0008;

        // Reset and quiet bus
        #195 rst = 1;
        @(negedge clk);
        check("reset a_ack", {31'd0, a_ack}, 32'd0);
        check("reset a_err", {31'd0, a_err}, 32'd0);
        check("reset a_dat", a_rdat, 32'd0);
        check("reset b_ack", {31'd0, b_ack}, 32'd0);
        check("reset b_err", {31'd0, b_err}, 32'd0);
        check("reset b_dat", b_rdat, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle a_resp", {30'd0, a_ack, a_err}, 32'd0);
            check("idle b_resp", {30'd0, b_ack, b_err}, 32'd0);
        end

        // Basic write/read, one wait state
        xfer(0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, 32'h0);
        xfer(0, 0, 32'h10, 4'hF, 32'h0,         0, 32'hDEAD_BEEF);

        // Byte lanes
        xfer(0, 1, 32'h10, 4'b0100, 32'h00AA_0000, 0, 32'h0);
        xfer(0, 0, 32'h10, 4'b0000, 32'h0,         0, 32'hDEAA_BEEF);
        xfer(0, 1, 32'h10, 4'b0000, 32'hFFFF_FFFF, 0, 32'h0);
        xfer(0, 0, 32'h10, 4'b1010, 32'h0,         0, 32'hDEAA_BEEF);

        // Errors and range boundary
        xfer(0, 1, 32'h0,    4'hF, 32'hCAFE_F00D, 0, 32'h0);
        xfer(0, 1, 32'hFFC,  4'hF, 32'h5A5A_5A5A, 0, 32'h0);
        xfer(0, 0, 32'hFFC,  4'hF, 32'h0,         0, 32'h5A5A_5A5A);
        xfer(0, 0, 32'h12,   4'hF, 32'h0,         1, 32'h0);
        xfer(0, 1, 32'h12,   4'hF, 32'h0,         1, 32'h0);
        xfer(0, 0, 32'h1000, 4'hF, 32'h0,         1, 32'h0);
        xfer(0, 1, 32'h1000, 4'hF, 32'h0,         1, 32'h0);
        xfer(0, 0, 32'h10,   4'hF, 32'h0,         0, 32'hDEAA_BEEF);
        xfer(0, 0, 32'h0,    4'hF, 32'h0,         0, 32'hCAFE_F00D);

        // Abort during WAIT
        xfer(0, 1, 32'h20, 4'hF, 32'h1111_1111, 0, 32'h0);
        a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 32'h20; a_sel = 4'hF; a_dat = 32'h2222_2222;
        @(negedge clk);
        a_stb = 0; a_cyc = 0;
        repeat (3) @(negedge clk);
        xfer(0, 0, 32'h20, 4'hF, 32'h0, 0, 32'h1111_1111);

        // Reset during a pending write
        xfer(0, 1, 32'h30, 4'hF, 32'h1234_5678, 0, 32'h0);
        a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 32'h30; a_sel = 4'hF; a_dat = 32'h8765_4321;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("in_reset a_ack", {31'd0, a_ack}, 32'd0);
        a_stb = 0; a_cyc = 0;
        @(negedge clk);
        check("in_reset a_err", {31'd0, a_err}, 32'd0);
        rst = 1;
        repeat (3) @(negedge clk);
        xfer(0, 0, 32'h30, 4'hF, 32'h0, 0, 32'h1234_5678);

        // Zero wait states, back-to-back reads with stb held
        for (int i = 0; i < 3; i++) xfer(1, 1, rd_adr[i], 4'hF, rd_dat[i], 0, 32'h0);
        c = cyc_cnt;
        for (int i = 0; i < 3; i++) begin
            e.err = 0;
            e.dat = rd_dat[i];
            e.cyc = c + 1 + 2 * i;
            qb.push_back(e);
        end
        b_cyc = 1; b_stb = 1; b_we = 0; b_sel = 4'hF; b_adr = rd_adr[0];
        for (int i = 0; i < 3; i++) begin
            t = 0;
            @(negedge clk);
            while (!(b_ack || b_err) && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!(b_ack || b_err)) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_timeout read %0d: got no termination, expected ack", i);
            end
            if (i < 2) b_adr = rd_adr[i + 1];
        end
        b_stb = 0; b_cyc = 0;

        repeat (4) @(negedge clk);
        check("scoreboard qa drained", qa.size(), 32'd0);
        check("scoreboard qb drained", qb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
